// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // A requested count of zero, or anything beyond the store, means "fill it all".
    function automatic logic [6:0] clamp_count(input logic [6:0] n);
        return ((n == 7'd0) || (n > 7'd64)) ? 7'd64 : n;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the boot source and the loader.
// Latency: n/a (wires only).
// Backpressure: a byte moves on a clock edge where byte_valid && byte_ready.
// Signals: byte_valid/byte_data driven by the source (master),
//          byte_ready driven by the loader (slave).
interface imem_loader_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input  byte_ready);
    modport slave  (input  byte_valid, input  byte_data, output byte_ready);

endinterface

// File: rtl/imem_ram.sv
// DEPTH x DATA_W instruction store: synchronous write, asynchronous read.
// Latency: write lands on the clock edge with we=1; read is combinational.
// Backpressure: none, a write is always accepted.
// Ports: clk, we/wa/wd write port, a/rd read port.
module imem_ram
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents deliberately survive reset so a reset CPU keeps its program.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[a];

endmodule

// File: rtl/imem_loader.sv
// Fills the instruction store from a big-endian byte stream, holding the CPU in reset until loaded.
// Latency: a word is visible on rd the cycle after its 4th byte; done follows the last byte by one cycle.
// Backpressure: byte_ready is high only while loading (registered, no path from byte_valid).
// Ports: clk, reset (sync, active-high), start/num_words session control, bs byte stream,
//        a/rd fetch port, busy/done/cpu_reset status, cksum_err when IMEM_LOADER_CHECKSUM_EN is defined
//        (then a trailing XOR checksum word follows the data words).
module imem_loader
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        num_words,
    imem_loader_if.slave      bs,
    input  logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] rd,
    output logic              busy,
    output logic              done,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic              cksum_err,
`endif
    output logic              cpu_reset
);

    loader_state_t     state_q, state_d;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [6:0]        word_cnt_q;
    logic [6:0]        target_q;
    logic [23:0]       asm_q;

    logic              start_ok;
    logic              accept;
    logic              word_end;
    logic              last_word;
    logic              store_we;
    logic [DATA_W-1:0] full_word;

    assign start_ok  = start && (state_q != LOAD);
    assign accept    = bs.byte_valid && bs.byte_ready;
    assign word_end  = accept && (byte_cnt_q == 2'd3);
    assign full_word = {asm_q, bs.byte_data};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] xor_acc_q;
    logic              cksum_err_q;
    logic              trailer;

    // Once every data word is stored, the next word is the checksum and is not written.
    assign trailer   = (word_cnt_q == target_q);
    assign last_word = trailer;
    assign store_we  = word_end && !trailer;
    assign cksum_err = cksum_err_q;
    assign cpu_reset = !((state_q == DONE) && !cksum_err_q);
`else
    assign last_word = (word_cnt_q == 7'(target_q - 7'd1));
    assign store_we  = word_end;
    assign cpu_reset = (state_q != DONE);
`endif

    assign busy          = (state_q == LOAD);
    assign done          = (state_q == DONE);
    assign bs.byte_ready = (state_q == LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = LOAD;
            LOAD:       if (word_end && last_word) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q  <= 2'd0;
            word_idx_q  <= '0;
            word_cnt_q  <= 7'd0;
            target_q    <= 7'd0;
            asm_q       <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc_q   <= '0;
            cksum_err_q <= 1'b0;
`endif
        end else if (start_ok) begin
            byte_cnt_q  <= 2'd0;
            word_idx_q  <= '0;
            word_cnt_q  <= 7'd0;
            target_q    <= clamp_count(num_words);
            asm_q       <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc_q   <= '0;
            cksum_err_q <= 1'b0;
`endif
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= {asm_q[15:0], bs.byte_data};
            if (store_we) begin
                // A full 64-word session ends with word_idx wrapping back to 0.
                word_idx_q <= word_idx_q + 1'b1;
                word_cnt_q <= word_cnt_q + 7'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_acc_q  <= xor_acc_q ^ full_word;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (word_end && trailer && (full_word != xor_acc_q)) begin
                cksum_err_q <= 1'b1;
            end
`endif
        end
    end

    imem_ram u_ram (
        .clk (clk),
        .we  (store_we),
        .wa  (word_idx_q),
        .wd  (full_word),
        .a   (a),
        .rd  (rd)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected words are queued as their bytes are driven
// and compared against the fetch port once the session completes.
module tb_imem_loader;
    import imem_pkg::*;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  num_words = 7'd0;
    logic [5:0]  a = 6'd0;
    logic [31:0] rd;
    logic        busy, done, cpu_reset;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        cksum_err;
`endif

    imem_loader_if bus();

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .bs        (bus),
        .a         (a),
        .rd        (rd),
        .busy      (busy),
        .done      (done),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .cksum_err (cksum_err),
`endif
        .cpu_reset (cpu_reset)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [31:0] model [64];
    logic [31:0] stim_words [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int waitc = 0;
        if (stall) begin
            bus.byte_valid = 1'b0;
            tick();
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        if (bus.byte_ready !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL byte_ready_timeout: byte_ready=%b required 1", bus.byte_ready);
        end
        tick();
    endtask

    task automatic drain_sb(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = e.addr;
            #1;
            n_cmp++;
            if (rd !== e.data) begin
                n_bad++;
                $display("FAIL %s rd@%0d: got %h required %h", tag, e.addr, rd, e.data);
            end
        end
    endtask

    task automatic pulse_start(input logic [6:0] cfg);
        start = 1'b1;
        num_words = cfg;
        tick();
        start = 1'b0;
    endtask

    // Loads stim_words[0..nw-1] (plus optional trailer) and checks status around the final handshake.
    task automatic load_words(input logic [6:0] cfg, input int nw, input bit stall,
                              input bit trl_en, input logic [31:0] trl, input bit exp_err,
                              input string tag);
        logic [7:0] bq[$];
        logic [31:0] w;
        int total;
        pulse_start(cfg);
        n_cmp++;
        if (busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s start: busy=%b byte_ready=%b required 1/1", tag, busy, bus.byte_ready);
        end
        for (int i = 0; i < nw; i++)
            for (int k = 0; k < 4; k++) bq.push_back(stim_words[i][31-8*k -: 8]);
        if (trl_en)
            for (int k = 0; k < 4; k++) begin
                w = trl;
                bq.push_back(w[31-8*k -: 8]);
            end
        total = bq.size();
        for (int j = 0; j < total; j++) begin
            if (j == total - 1) begin
                n_cmp++;
                if (done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s early_done: done=%b required 0", tag, done);
                end
            end
            send_byte(bq[j], stall && (j % 2 == 1));
            if ((j % 4 == 3) && (j / 4 < nw)) begin
                sb.push_back('{addr: 6'(j / 4), data: stim_words[j / 4]});
                model[j / 4] = stim_words[j / 4];
            end
        end
        bus.byte_valid = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || cpu_reset !== exp_err || busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s end_status: done=%b cpu_reset=%b busy=%b byte_ready=%b required 1/%b/0/0",
                     tag, done, cpu_reset, busy, bus.byte_ready, exp_err);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        n_cmp++;
        if (cksum_err !== exp_err) begin
            n_bad++;
            $display("FAIL %s cksum_err: got %b required %b", tag, cksum_err, exp_err);
        end
`endif
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if (bus.byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: byte_ready=%b busy=%b done=%b cpu_reset=%b required 0/0/0/1",
                     tag, bus.byte_ready, busy, done, cpu_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_idle("reset_state");
    endtask

    task automatic test_two_word();
        stim_words[0] = 32'h20020005;
        stim_words[1] = 32'h2003000C;
        load_words(7'd2, 2, 1'b0, 1'b0, 32'h0, 1'b0, "two_word");
        drain_sb("two_word");
    endtask

    task automatic test_stalls();
        stim_words[0] = 32'h20020005;
        stim_words[1] = 32'h2003000C;
        load_words(7'd2, 2, 1'b1, 1'b0, 32'h0, 1'b0, "stalls");
        drain_sb("stalls");
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < 64; i++) stim_words[i] = 32'hA5000000 | i;
        load_words(7'd0, 64, 1'b0, 1'b0, 32'h0, 1'b0, "full_depth");
        drain_sb("full_depth");
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] junk [5] = '{8'h99, 8'h88, 8'h77, 8'h66, 8'h55};
        pulse_start(7'd2);
        for (int j = 0; j < 5; j++) send_byte(junk[j], 1'b0);
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("reset_mid_load");
        stim_words[0] = 32'h12345678;
        load_words(7'd1, 1, 1'b0, 1'b0, 32'h0, 1'b0, "after_reset");
        sb.push_back('{addr: 6'd1, data: model[1]});
        drain_sb("after_reset");
    endtask

    task automatic test_start_ignored_reload();
        logic [31:0] ws [2] = '{32'h0A0B0C0D, 32'h01020304};
        pulse_start(7'd2);
        for (int j = 0; j < 8; j++) begin
            if (j == 2) begin
                bus.byte_valid = 1'b0;
                pulse_start(7'd1);
            end
            send_byte(ws[j / 4][31 - 8*(j % 4) -: 8], 1'b0);
            if (j == 3) begin
                n_cmp++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL start_ignored: done=%b busy=%b required 0/1", done, busy);
                end
            end
        end
        bus.byte_valid = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL start_ignored end: done=%b cpu_reset=%b required 1/0", done, cpu_reset);
        end
        model[0] = ws[0];
        model[1] = ws[1];
        sb.push_back('{addr: 6'd0, data: ws[0]});
        sb.push_back('{addr: 6'd1, data: ws[1]});
        drain_sb("start_ignored");
        stim_words[0] = 32'hDEADBEEF;
        load_words(7'd1, 1, 1'b0, 1'b0, 32'h0, 1'b0, "reload");
        sb.push_back('{addr: 6'd1, data: 32'h01020304});
        drain_sb("reload");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        stim_words[0] = 32'h11111111;
        stim_words[1] = 32'h22222222;
        load_words(7'd2, 2, 1'b0, 1'b1, 32'h33333333, 1'b0, "cksum_ok");
        drain_sb("cksum_ok");
        load_words(7'd2, 2, 1'b0, 1'b1, 32'h33333334, 1'b1, "cksum_bad");
        drain_sb("cksum_bad");
    endtask
`endif

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
        test_reset();
        test_two_word();
        test_stalls();
        test_full_depth();
        test_reset_mid_load();
        test_start_ignored_reload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
